reg_file_mp: RTL

//  Parametrised multi-read-port register file for the MIPS datapath; next generation of the 2-read/1-write file.

---
 rtl/mips_pkg.sv | 13 +
 rtl/reg_file_rd_port.sv | 31 +++
 rtl/reg_file_mp.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: clear-engine state encoding and default widths.
package mips_pkg;

  localparam int unsigned MIPS_DATA_W = 32;
  localparam int unsigned MIPS_ADDR_W = 5;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage : mips_pkg

// File: rtl/reg_file_rd_port.sv
// One combinational read port: zero-register check, write bypass, array and pending select.
module reg_file_rd_port #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0]                   rd_addr,
  input  logic                                byp_en,
  input  logic [ADDR_W-1:0]                   wr_addr,
  input  logic [DATA_W-1:0]                   wr_data,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    mem,
  input  logic [2**ADDR_W-1:0]                pend,
  output logic [DATA_W-1:0]                   rd_data,
  output logic                                rd_pend
);

  // Priority: hard-wired zero, then same-cycle write forward, then stored value.
  always_comb begin
    rd_data = mem[rd_addr];
    rd_pend = pend[rd_addr];
    if (BYPASS && byp_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
    if (ZERO_REG && (rd_addr == '0)) begin
      rd_data = '0;
      rd_pend = 1'b0;
    end
  end

endmodule : reg_file_rd_port

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write bypass, optional zero register,
// per-entry pending scoreboard and a sequenced bulk-clear engine.
module reg_file_mp
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = MIPS_DATA_W,
  parameter int unsigned ADDR_W   = MIPS_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pend,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [2**ADDR_W-1:0]       pend_vec,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       clr_done
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             pend_q, pend_d;
  clr_state_e                   state_q, state_d;
  logic [ADDR_W-1:0]            idx_q, idx_d;
  logic                         clr_busy_q, clr_busy_d;
  logic                         clr_done_q, clr_done_d;

  logic clearing;
  logic wr_ok;
  logic rsv_ok;

  assign clearing = (state_q == CLR_CLEAR);
  assign wr_ok    = wr_en  && !clearing && !(ZERO_REG && (wr_addr  == '0));
  assign rsv_ok   = rsv_en && !clearing && !(ZERO_REG && (rsv_addr == '0));

  // Clear engine next state; busy/done are registered decodes of the next state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_CLEAR;
          idx_d   = '0;
        end
      end
      CLR_CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = CLR_DONE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
    clr_busy_d = (state_d == CLR_CLEAR);
    clr_done_d = (state_d == CLR_DONE);
  end

  // Clear engine state and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= CLR_IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Storage update: sweep owns the array while clearing; otherwise write, then reserve (reserve wins).
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (clearing) begin
      mem_d[idx_q]  = '0;
      pend_d[idx_q] = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_d[wr_addr]  = wr_data;
        pend_d[wr_addr] = 1'b0;
      end
      if (rsv_ok) begin
        pend_d[rsv_addr] = 1'b1;
      end
    end
  end

  // Array and scoreboard registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q  <= '0;
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .rd_addr (rd_addr[p*ADDR_W +: ADDR_W]),
      .byp_en  (wr_en && !clearing),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .mem     (mem_q),
      .pend    (pend_q),
      .rd_data (rd_data[p*DATA_W +: DATA_W]),
      .rd_pend (rd_pend[p])
    );
  end

  assign pend_vec = pend_q;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule : reg_file_mp
